addr_bus_arb: RTL and testbench

Parametrised, registered address bus that replaces the fixed-select combinational address mux.
- NUM_SRC requesters (PC, SP, MEM, IMM, FETCH, DECODE, ALU, vectors, ...) each present an address and a request.
- The block arbitrates among them and drives one registered address, a valid flag and a one-hot grant to the memory/decode side.
- Supports multi-cycle bus locking (e.g. lo/hi vector fetch), a forced-select override for the control unit, and a starvation guard.

---
 rtl/addr_bus_arb_pkg.sv | 23 ++
 rtl/addr_bus_arb_if.sv | 30 +++
 rtl/addr_bus_arb_rr_arbiter.sv | 46 ++++
 rtl/addr_bus_arb.sv | 102 ++++++++++
 tb/tb_addr_bus_arb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/addr_bus_arb_pkg.sv
// Shared types and constants for the registered address bus arbiter.
// Source indices name the requesters of the CPU address bus.
package addr_bus_pkg;

  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int SRC_ZERO   = 0;
  localparam int SRC_PC     = 1;
  localparam int SRC_SP     = 2;
  localparam int SRC_MEM    = 7;
  localparam int SRC_IMM    = 8;
  localparam int SRC_FETCH  = 9;
  localparam int SRC_DECODE = 10;
  localparam int SRC_ALU    = 11;
  localparam int SRC_VEC    = 13;

endpackage

// File: rtl/addr_bus_arb_if.sv
// Requester-side and bus-side signals of the address arbiter.
// The master side drives requests; the slave side is the arbiter itself.
interface addr_bus_arb_if
  import addr_bus_pkg::*;
#(
  parameter int NUM_SRC      = 8,
  parameter int SIGNAL_WIDTH = ADDR_WIDTH,
  parameter int IDX_WIDTH    = 4
);
  logic [NUM_SRC*SIGNAL_WIDTH-1:0] src_addr;
  logic [NUM_SRC-1:0]              src_req;
  logic [NUM_SRC-1:0]              src_lock;
  logic                            force_en;
  logic [IDX_WIDTH-1:0]            force_sel;
  logic [SIGNAL_WIDTH-1:0]         addr_out;
  logic                            addr_valid;
  logic [NUM_SRC-1:0]              grant;
  logic [IDX_WIDTH-1:0]            owner;
  logic                            lock_expired;

  modport master (
    output src_addr, src_req, src_lock, force_en, force_sel,
    input  addr_out, addr_valid, grant, owner, lock_expired
  );

  modport slave (
    input  src_addr, src_req, src_lock, force_en, force_sel,
    output addr_out, addr_valid, grant, owner, lock_expired
  );
endinterface

// File: rtl/addr_bus_arb_rr_arbiter.sv
// Combinational arbiter: round-robin from a pointer, or lowest index first.
// Masked-out requesters never win.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  exclude,
  input  logic          mode,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] eff;
  logic [N-1:0] rot;
  logic [IW:0]  sum;
  logic         found;

  assign eff = req & ~exclude;
  assign any = |eff;
  // rot[k] is the requester k places after the pointer
  assign rot = N'({eff, eff} >> ptr);

  always_comb begin
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        if (rot[k] && !found) begin
          found = 1'b1;
          sum   = {1'b0, ptr} + (IW+1)'(k);
          if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
          idx = sum[IW-1:0];
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (eff[k]) idx = IW'(k);
      end
    end
  end

  assign onehot = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/addr_bus_arb.sv
// Registered address bus arbiter with bus locking, control-unit force and
// lock-length limit; all outputs are registered one edge after sampling.
module addr_bus_arb
  import addr_bus_pkg::*;
#(
  parameter int                    SIGNAL_WIDTH = ADDR_WIDTH,
  parameter int                    NUM_SRC      = 8,
  parameter int                    IDX_WIDTH    = 4,
  parameter bit                    RR_MODE      = 1'b1,
  parameter int                    LOCK_MAX     = 4,
  parameter logic [SIGNAL_WIDTH-1:0] IDLE_ADDR  = '0
) (
  input logic            clk,
  input logic            reset,
  addr_bus_arb_if.slave  bus
);
  state_t                  state, state_nxt;
  logic [7:0]              lock_cnt, lock_cnt_nxt;
  logic [IDX_WIDTH-1:0]    ptr, ptr_nxt, owner_q, owner_nxt;
  logic [NUM_SRC-1:0]      grant_q, grant_nxt, owner_mask, exclude, arb_onehot;
  logic [SIGNAL_WIDTH-1:0] addr_q, addr_nxt, win_addr;
  logic                    valid_q, valid_nxt, expired_q, expired_nxt;
  logic                    owner_holds, holding, expiring, force_ok;
  logic                    arb_any, use_arb, win_any, win_lock;
  logic [IDX_WIDTH-1:0]    arb_idx, win_idx;

  assign owner_mask  = NUM_SRC'(1) << owner_q;
  assign owner_holds = (state == LOCKED) && |(bus.src_req & owner_mask)
                       && |(bus.src_lock & owner_mask);
  assign holding  = owner_holds && (lock_cnt < 8'(LOCK_MAX));
  assign expiring = owner_holds && (lock_cnt >= 8'(LOCK_MAX));
  assign exclude  = expiring ? owner_mask : '0;
  // out-of-range force selects fall through to normal arbitration
  assign force_ok = bus.force_en && (32'(bus.force_sel) < NUM_SRC);

  rr_arbiter #(.N(NUM_SRC), .IW(IDX_WIDTH)) u_arb (
    .req     (bus.src_req),
    .ptr     (ptr),
    .exclude (exclude),
    .mode    (RR_MODE),
    .onehot  (arb_onehot),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  assign use_arb  = !holding && !force_ok && arb_any;
  assign win_any  = holding || force_ok || arb_any;
  assign win_idx  = holding ? owner_q : (force_ok ? bus.force_sel : arb_idx);
  assign win_lock = |(bus.src_lock & (NUM_SRC'(1) << win_idx));
  assign win_addr = SIGNAL_WIDTH'(bus.src_addr >> (32'(win_idx) * SIGNAL_WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      ptr       <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      addr_q    <= IDLE_ADDR;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      ptr       <= ptr_nxt;
      owner_q   <= owner_nxt;
      grant_q   <= grant_nxt;
      addr_q    <= addr_nxt;
      valid_q   <= valid_nxt;
      expired_q <= expired_nxt;
    end
  end

  always_comb begin
    state_nxt    = IDLE;
    lock_cnt_nxt = '0;
    ptr_nxt      = ptr;
    if (holding) begin
      state_nxt    = LOCKED;
      lock_cnt_nxt = lock_cnt + 8'd1;
    end else if (win_any) begin
      state_nxt    = win_lock ? LOCKED : GRANT;
      lock_cnt_nxt = win_lock ? 8'd1 : 8'd0;
    end
    if (use_arb && RR_MODE)
      ptr_nxt = (arb_idx == IDX_WIDTH'(NUM_SRC - 1)) ? '0 : arb_idx + IDX_WIDTH'(1);
  end

  always_comb begin
    valid_nxt   = win_any;
    owner_nxt   = win_any ? win_idx : '0;
    grant_nxt   = win_any ? (NUM_SRC'(1) << win_idx) : '0;
    addr_nxt    = win_any ? win_addr : IDLE_ADDR;
    expired_nxt = expiring;
  end

  assign bus.addr_out     = addr_q;
  assign bus.addr_valid   = valid_q;
  assign bus.grant        = grant_q;
  assign bus.owner        = owner_q;
  assign bus.lock_expired = expired_q;
endmodule

// File: tb/tb_addr_bus_arb.sv
// Scoreboard bench for addr_bus_arb: a 16-source round-robin instance and an
// 8-source fixed-priority instance; expected outputs are queued as driven.
module tb_addr_bus_arb;
  import addr_bus_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [15:0] grant;
    logic [3:0]  owner;
    logic [15:0] addr;
    logic        expired;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t got, want;

  addr_bus_arb_if #(.NUM_SRC(16), .SIGNAL_WIDTH(16), .IDX_WIDTH(4)) bus_a ();
  addr_bus_arb_if #(.NUM_SRC(8),  .SIGNAL_WIDTH(16), .IDX_WIDTH(4)) bus_b ();

  addr_bus_arb #(.SIGNAL_WIDTH(16), .NUM_SRC(16), .IDX_WIDTH(4), .RR_MODE(1'b1),
                 .LOCK_MAX(4), .IDLE_ADDR(16'h0000))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  addr_bus_arb #(.SIGNAL_WIDTH(16), .NUM_SRC(8), .IDX_WIDTH(4), .RR_MODE(1'b0),
                 .LOCK_MAX(4), .IDLE_ADDR(16'h0000))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input logic v, input int o, input logic [15:0] a, input logic x);
    exp_t e;
    e.valid   = v;
    e.grant   = v ? (16'd1 << o) : 16'd0;
    e.owner   = v ? 4'(o) : 4'd0;
    e.addr    = a;
    e.expired = x;
    return e;
  endfunction

  function automatic exp_t obs_a();
    return {bus_a.addr_valid, bus_a.grant, bus_a.owner, bus_a.addr_out, bus_a.lock_expired};
  endfunction

  function automatic exp_t obs_b();
    return {bus_b.addr_valid, 8'h00, bus_b.grant, bus_b.owner, bus_b.addr_out, bus_b.lock_expired};
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("valid=%b grant=%h owner=%0d addr=%h expired=%b",
                     e.valid, e.grant, e.owner, e.addr, e.expired);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus_a.src_req = '0; bus_a.src_lock = '0; bus_a.force_en = 1'b0; bus_a.force_sel = '0;
    bus_b.src_req = '0; bus_b.src_lock = '0; bus_b.force_en = 1'b0; bus_b.force_sel = '0;
    for (int i = 0; i < 16; i++) bus_a.src_addr[i*16 +: 16] = 16'hA000 | 16'(i);
    for (int i = 0; i < 8; i++)  bus_b.src_addr[i*16 +: 16] = 16'hB000 | 16'(i);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus_a.src_req = 16'h0002; bus_a.src_lock = 16'h0002;
    bus_a.src_addr[1*16 +: 16] = 16'hC000;
    sb.push_back(mk(1, 1, 16'hC000, 0));
    @(posedge clk); #1;
    got = obs_a(); want = sb.pop_front(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_prelock: got %s want %s", fmt(got), fmt(want)); end
    n_vec++;
    if (dut_a.state !== LOCKED) begin n_err++; $display("FAIL reset_prelock_state: got %0d want %0d", dut_a.state, LOCKED); end
    #3 reset = 1'b1;
    sb.push_back(mk(0, 0, 16'h0000, 0));
    #1;
    got = obs_a(); want = sb.pop_front(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_midlock: got %s want %s", fmt(got), fmt(want)); end
    n_vec++;
    if (dut_a.state !== IDLE) begin n_err++; $display("FAIL reset_midlock_state: got %0d want %0d", dut_a.state, IDLE); end
    sb.push_back(mk(0, 0, 16'h0000, 0));
    @(posedge clk); #1;
    got = obs_a(); want = sb.pop_front(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_held: got %s want %s", fmt(got), fmt(want)); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus_a.src_req = 16'h0002;
    bus_a.src_addr[1*16 +: 16] = 16'hC000;
    sb.push_back(mk(1, 1, 16'hC000, 0));
    @(posedge clk); #1;
    bus_a.src_req = 16'h0000;
    sb.push_back(mk(0, 0, 16'h0000, 0));
    for (int c = 0; c < 2; c++) begin
      got = obs_a(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL single_req cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
      if (c == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_rr_fairness();
    int own[6] = '{1, 2, 7, 1, 2, 7};
    do_reset();
    bus_a.src_req = 16'h0086;
    for (int c = 0; c < 6; c++) begin
      sb.push_back(mk(1, own[c], 16'hA000 | 16'(own[c]), 0));
      @(posedge clk); #1;
      got = obs_a(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL rr_fair cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    bus_b.src_req = 8'h86;
    for (int c = 0; c < 4; c++) begin
      sb.push_back(mk(1, 1, 16'hB001, 0));
      @(posedge clk); #1;
      got = obs_b(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL fixed_prio cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_lock_expiry();
    do_reset();
    bus_a.src_req = 16'h2000; bus_a.src_lock = 16'h2000;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) bus_a.src_req = 16'h2004;
      if (c == 4)      sb.push_back(mk(1, 2,  16'hA002, 1));
      else             sb.push_back(mk(1, 13, 16'hA00D, 0));
      @(posedge clk); #1;
      got = obs_a(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL lock_expiry cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_force();
    do_reset();
    bus_b.force_en = 1'b1; bus_b.force_sel = 4'd7;
    bus_b.src_addr[7*16 +: 16] = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) sb.push_back(mk(1, 7, 16'h1234, 0));
      if (c == 1) begin bus_b.force_sel = 4'hF; sb.push_back(mk(0, 0, 16'h0000, 0)); end
      if (c == 2) begin bus_b.src_req = 8'h04; sb.push_back(mk(1, 2, 16'hB002, 0)); end
      @(posedge clk); #1;
      got = obs_b(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL force cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_force_deferred();
    do_reset();
    bus_a.src_req = 16'h0002; bus_a.src_lock = 16'h0002;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin bus_a.force_en = 1'b1; bus_a.force_sel = 4'd7; end
      if (c == 3) bus_a.src_lock = 16'h0000;
      if (c == 4) begin bus_a.force_en = 1'b0; bus_a.src_req = 16'h0000; end
      if (c < 3)       sb.push_back(mk(1, 1, 16'hA001, 0));
      else if (c == 3) sb.push_back(mk(1, 7, 16'hA007, 0));
      else             sb.push_back(mk(0, 0, 16'h0000, 0));
      @(posedge clk); #1;
      got = obs_a(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL force_deferred cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_lock_tracking();
    logic [15:0] a[3] = '{16'hFFFC, 16'hFFFD, 16'h0000};
    do_reset();
    bus_a.src_req = 16'h0400; bus_a.src_lock = 16'h0400;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) begin
        bus_a.src_addr[10*16 +: 16] = a[c];
        sb.push_back(mk(1, 10, a[c], 0));
      end else begin
        bus_a.src_req = '0; bus_a.src_lock = '0;
        sb.push_back(mk(0, 0, a[c], 0));
      end
      @(posedge clk); #1;
      got = obs_a(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL lock_track cyc %0d: got %s want %s", c, fmt(got), fmt(want)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed_priority();
    test_lock_expiry();
    test_force();
    test_force_deferred();
    test_lock_tracking();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
